// File: rtl/adder_sequencer_pkg.sv
// Shared constants and state encoding for the byte-serial adder sequencer.
package adder_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/eight_bit_adder.sv
// Byte-wide ripple adder used as the single datapath element of the sequencer.
module eight_bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    // Plain 8-bit add with carry in and carry out.
    assign {co, s} = 9'(a) + 9'(b) + 9'(ci);

endmodule

// File: rtl/adder_sequencer.sv
// Byte-serial adder/subtractor: one byte per clock through a single 8-bit
// adder, LSB byte first, with a valid/ready handshake on both sides.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an operation, start_ready=1
// ST_RUN  | adding byte[idx_q] each clock, carry kept in carry_q
// ST_DONE | result/cout/ovf held with res_valid=1 until res_ready
module adder_sequencer
    import adder_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [8*NBYTES-1:0]     op_a,
    input  logic [8*NBYTES-1:0]     op_b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [8*NBYTES-1:0]     result,
    output logic                    cout,
    output logic                    ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               start_ready_q, start_ready_d;
    logic               res_valid_q, res_valid_d;

    logic [BYTE_W-1:0]  add_a, add_b, add_s;
    logic               add_co;

    // Select the operand bytes addressed by the byte index.
    always_comb begin
        add_a = op_a_q[int'(idx_q)*BYTE_W +: BYTE_W];
        add_b = op_b_q[int'(idx_q)*BYTE_W +: BYTE_W];
    end

    eight_bit_adder u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    // Next-state logic; subtraction is folded into the operand capture so
    // RUN never needs to know the operation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    op_a_d  = op_a;
                    op_b_d  = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q)*BYTE_W +: BYTE_W] = add_s;
                carry_d = add_co;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    cout_d  = add_co;
                    ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) &&
                              (add_s[BYTE_W-1] != op_a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        start_ready_d = (state_d == ST_IDLE);
        res_valid_d   = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            result_q      <= result_d;
            cout_q        <= cout_d;
            ovf_q         <= ovf_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer with NBYTES=4.
module tb_adder_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic        sub;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [31:0] result;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    adder_sequencer #(.NBYTES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push the modelled result, issue the op, wait for the result, compare,
    // optionally stall res_ready for 'hold' cycles with junk start requests.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic s, input int hold);
        logic [31:0] bb;
        logic        c;
        logic [32:0] full;
        exp_t        e;
        int          lat;
        bb   = s ? ~b : b;
        c    = s ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bb} + 33'(c);
        e.result = full[31:0];
        e.cout   = full[32];
        e.ovf    = (a[31] == bb[31]) && (full[31] != a[31]);
        sb.push_back(e);

        lat = 0;
        while (!start_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!start_ready) check_val("accept_timeout", 0, 1);
        start_valid = 1'b1;
        op_a = a; op_b = b; cin = ci; sub = s;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; cin = ~ci; sub = ~s;

        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", 64'(lat), 64'd4);
        if (res_valid) begin
            e = sb.pop_front();
            check_val("result", 64'(result), 64'(e.result));
            check_val("cout",   64'(cout),   64'(e.cout));
            check_val("ovf",    64'(ovf),    64'(e.ovf));
        end

        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            check_val("hold_result", 64'(result),      64'(e.result));
            check_val("hold_srdy",   64'(start_ready), 64'd0);
            check_val("hold_rvld",   64'(res_valid),   64'd1);
        end

        res_ready   = 1'b1;
        start_valid = (hold > 0);
        @(posedge clk); #1;
        res_ready   = 1'b0;
        start_valid = 1'b0;
        check_val("leave_rvld", 64'(res_valid),   64'd0);
        check_val("leave_srdy", 64'(start_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_srdy",   64'(start_ready), 64'd1);
        check_val("rst_rvld",   64'(res_valid),   64'd0);
        check_val("rst_result", 64'(result),      64'd0);
        check_val("rst_cout",   64'(cout),        64'd0);
        check_val("rst_ovf",    64'(ovf),         64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 3);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 1'b1, 0);
        for (int k = 0; k < 6; k++)
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));

        // Abort: reset two cycles into RUN.
        start_valid = 1'b1;
        op_a = 32'hAAAA_5555; op_b = 32'h1111_1111; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("abort_srdy",   64'(start_ready), 64'd1);
        check_val("abort_rvld",   64'(res_valid),   64'd0);
        check_val("abort_result", 64'(result),      64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check_val("abort_no_res", 64'(seen), 64'd0);

        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0);
        check_val("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
